// File: rtl/uram_addr_gen.sv
// rtl/uram_addr_gen.sv - URAM write-address generator with per-channel skew chain and trigger latch
//
// Purpose:
//   Generates the channel-0 URAM write pattern in the memclk domain. While
//   running, three of every four clocks are write cycles. The lower address
//   steps once per write, and the upper (block) address steps on each
//   capture pulse from the event timer. Channel k receives channel 0's
//   address and write enable delayed by k clocks. A trigger latches the
//   current block address and holds it until it is acknowledged.
//
// Ports:
//   memclk_i        memory clock (only clock)
//   memrst_i        asynchronous active-high reset
//   running_i       acquisition enable; low stops writing on the next clock
//   start_i         one-cycle start pulse; restarts all counters
//   capture_i       one-cycle pulse; advances the block address
//   trig_i          one-cycle trigger; latches the current block address
//   trig_ack_i      acknowledge for the latched trigger address
//   addr_o          per-channel {upper, lower}; channel k at [k*AW +: AW]
//   we_o            per-channel write enable
//   trig_addr_o     latched block address
//   trig_valid_o    trig_addr_o holds an unacknowledged address
//   trig_overflow_o sticky: trigger arrived while previous one was pending

module uram_addr_gen #(
   parameter int NCHAN      = 8,
   parameter int UPPER_BITS = 10,
   parameter int LOWER_BITS = 2    // only 2 is supported
) (
   input  logic                                    memclk_i,
   input  logic                                    memrst_i,
   input  logic                                    running_i,
   input  logic                                    start_i,
   input  logic                                    capture_i,
   input  logic                                    trig_i,
   input  logic                                    trig_ack_i,
   output logic [NCHAN*(UPPER_BITS+LOWER_BITS)-1:0] addr_o,
   output logic [NCHAN-1:0]                        we_o,
   output logic [UPPER_BITS-1:0]                   trig_addr_o,
   output logic                                    trig_valid_o,
   output logic                                    trig_overflow_o
);

   localparam int AW = UPPER_BITS + LOWER_BITS;

   // ------------------------------------------------------------------
   // Channel-0 state
   // ------------------------------------------------------------------
   logic                  r_run;
   logic [1:0]            r_phase;
   logic [LOWER_BITS-1:0] r_lo;
   logic [UPPER_BITS-1:0] r_up;

   logic                  w_run_nxt;
   logic [1:0]            w_phase_nxt;
   logic [LOWER_BITS-1:0] w_lo_nxt;
   logic [UPPER_BITS-1:0] w_up_nxt;

   logic                  w_start;
   logic                  w_we0;

   // A start pulse only counts while acquisition is enabled.
   assign w_start = start_i & running_i;

   // Phase 1 is the idle slot of the 4-clock write pattern.
   assign w_we0 = r_run & (r_phase != 2'd1);

   always_comb begin
      w_run_nxt   = r_run;
      w_phase_nxt = r_phase;
      w_lo_nxt    = r_lo;
      w_up_nxt    = r_up;
      if (w_start) begin
         // Start wins over a coincident capture.
         w_run_nxt   = 1'b1;
         w_phase_nxt = '0;
         w_lo_nxt    = '0;
         w_up_nxt    = '0;
      end else if (!running_i) begin
         // Stop writing but keep the address position.
         w_run_nxt = 1'b0;
      end else if (r_run) begin
         w_phase_nxt = r_phase + 2'd1;
         if (w_we0) begin
            // Lower address wraps on its own; it never carries into up.
            w_lo_nxt = r_lo + LOWER_BITS'(1);
         end
         if (capture_i) begin
            w_up_nxt = r_up + UPPER_BITS'(1);
         end
      end
   end

   always_ff @(posedge memclk_i or posedge memrst_i) begin
      if (memrst_i) begin
         r_run   <= 1'b0;
         r_phase <= '0;
         r_lo    <= '0;
         r_up    <= '0;
      end else begin
         r_run   <= w_run_nxt;
         r_phase <= w_phase_nxt;
         r_lo    <= w_lo_nxt;
         r_up    <= w_up_nxt;
      end
   end

   // ------------------------------------------------------------------
   // Trigger address latch with valid/ack handshake
   // ------------------------------------------------------------------
   logic                  r_trig_valid;
   logic                  r_trig_ovf;
   logic [UPPER_BITS-1:0] r_trig_addr;

   logic                  w_trig_take;
   logic                  w_trig_lost;
   logic                  w_trig_valid_nxt;
   logic                  w_trig_ovf_nxt;
   logic [UPPER_BITS-1:0] w_trig_addr_nxt;

   // A trigger is accepted when the slot is free or being freed this cycle;
   // otherwise it is dropped and flagged.
   assign w_trig_take = trig_i & r_run & (~r_trig_valid | trig_ack_i);
   assign w_trig_lost = trig_i & r_run & r_trig_valid & ~trig_ack_i;

   always_comb begin
      w_trig_addr_nxt  = r_trig_addr;
      w_trig_valid_nxt = r_trig_valid;
      w_trig_ovf_nxt   = r_trig_ovf;
      if (w_trig_take) begin
         w_trig_addr_nxt  = r_up;
         w_trig_valid_nxt = 1'b1;
      end else if (trig_ack_i) begin
         w_trig_valid_nxt = 1'b0;
      end
      if (w_start) begin
         w_trig_ovf_nxt = 1'b0;
      end else if (w_trig_lost) begin
         w_trig_ovf_nxt = 1'b1;
      end
   end

   always_ff @(posedge memclk_i or posedge memrst_i) begin
      if (memrst_i) begin
         r_trig_addr  <= '0;
         r_trig_valid <= 1'b0;
         r_trig_ovf   <= 1'b0;
      end else begin
         r_trig_addr  <= w_trig_addr_nxt;
         r_trig_valid <= w_trig_valid_nxt;
         r_trig_ovf   <= w_trig_ovf_nxt;
      end
   end

   assign trig_addr_o     = r_trig_addr;
   assign trig_valid_o    = r_trig_valid;
   assign trig_overflow_o = r_trig_ovf;

   // ------------------------------------------------------------------
   // Per-channel skew chain: channel k is channel k-1 delayed one clock
   // ------------------------------------------------------------------
   logic [NCHAN-1:0][AW-1:0] w_ch_addr;
   logic [NCHAN-1:0]         w_ch_we;

   // Channel 0 comes straight from the state registers, no extra stage.
   assign w_ch_addr[0] = {r_up, r_lo};
   assign w_ch_we[0]   = w_we0;

   for (genvar k = 1; k < NCHAN; k++) begin : g_chain
      logic [AW-1:0] r_addr;
      logic          r_we;

      always_ff @(posedge memclk_i or posedge memrst_i) begin
         if (memrst_i) begin
            r_addr <= '0;
            r_we   <= 1'b0;
         end else begin
            r_addr <= w_ch_addr[k-1];
            r_we   <= w_ch_we[k-1];
         end
      end

      assign w_ch_addr[k] = r_addr;
      assign w_ch_we[k]   = r_we;
   end

   assign addr_o = w_ch_addr;
   assign we_o   = w_ch_we;

endmodule
